// File: rtl/tx_send_scheduler.sv
// tx_send_scheduler: queues 6-bit buffer-index requests and issues gap-spaced TX send commands.
// Define TX_SEND_SCHED_STATS_EN to add saturating stat_sent / stat_dropped counters.
module tx_send_scheduler #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_SHIFT = 19,
    parameter logic [24:0] BASE_ADDR  = 25'h0,
    parameter int unsigned GAP_CYCLES = 64
) (
    input  logic                        clock_clk,
    input  logic                        reset_reset_n,
    input  logic [5:0]                  req_start_ram_addr,
    input  logic                        req_signal,
    input  logic                        mac_inited,
    input  logic                        clear_overflow,
    output logic [24:0]                 send_control_start_ram_addr,
    output logic                        send_control_cmd_send,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow_sticky
`ifdef TX_SEND_SCHED_STATS_EN
    ,
    output logic [15:0]                 stat_sent,
    output logic [15:0]                 stat_dropped
`endif
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned ADDR_W = 25;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [5:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic               r_req_d;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_cmd_send;
    logic               r_overflow;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_accept;
    logic               w_drop;

    assign w_push   = req_signal & ~r_req_d;
    assign w_full   = (r_level == LVL_W'(FIFO_DEPTH));
    // A full FIFO still takes the push when an entry leaves on the same edge.
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_drop   = w_push & ~w_accept;

    assign send_control_start_ram_addr = r_addr;
    assign send_control_cmd_send       = r_cmd_send;
    assign fifo_level                  = r_level;
    assign overflow_sticky             = r_overflow;

    // State register
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state; the FIFO is popped on the edge that enters LOAD
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if ((r_level != '0) && mac_inited) begin
                    w_next_state = LOAD;
                    w_pop        = 1'b1;
                end
            end
            LOAD:    w_next_state = SEND;
            SEND:    w_next_state = GAP;
            GAP: begin
                if (r_gap_cnt == '0) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Inter-packet gap counter, loaded as the strobe retires
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_gap_cnt <= '0;
        end else if (r_state == SEND) begin
            r_gap_cnt <= GAP_W'(GAP_CYCLES - 1);
        end else if ((r_state == GAP) && (r_gap_cnt != '0)) begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        end
    end

    // FIFO storage needs no reset; pointers and level define validity
    always_ff @(posedge clock_clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= req_start_ram_addr;
        end
    end

    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_req_d    <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_addr     <= '0;
            r_cmd_send <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_req_d    <= req_signal;
            r_cmd_send <= (r_state == LOAD);
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_addr   <= BASE_ADDR + (ADDR_W'(r_mem[r_rd_ptr]) << ADDR_SHIFT);
            end
            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef TX_SEND_SCHED_STATS_EN
    logic [15:0] r_stat_sent;
    logic [15:0] r_stat_dropped;

    assign stat_sent    = r_stat_sent;
    assign stat_dropped = r_stat_dropped;

    // Saturating counters; a clear discards a coincident increment
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_stat_sent    <= '0;
            r_stat_dropped <= '0;
        end else if (clear_overflow) begin
            r_stat_sent    <= '0;
            r_stat_dropped <= '0;
        end else begin
            if ((r_state == LOAD) && (r_stat_sent != 16'hFFFF)) begin
                r_stat_sent <= r_stat_sent + 16'd1;
            end
            if (w_drop && (r_stat_dropped != 16'hFFFF)) begin
                r_stat_dropped <= r_stat_dropped + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tx_send_scheduler.sv
// Bench for tx_send_scheduler: vector table plus scoreboarded sends and directed corner cases.
`timescale 1ns/1ps
module tb_tx_send_scheduler;

    localparam int unsigned GAP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  req_idx = '0;
    logic        req_sig = 1'b0;
    logic        mac = 1'b0;
    logic        clr = 1'b0;
    logic [24:0] addr;
    logic        cmd;
    logic [3:0]  level;
    logic        sticky;

    logic [5:0]  w_req_idx = '0;
    logic        w_req_sig = 1'b0;
    logic        w_mac = 1'b0;
    logic        w_clr = 1'b0;
    logic [24:0] w_addr;
    logic        w_cmd;
    logic [3:0]  w_level;
    logic        w_sticky;

`ifdef TX_SEND_SCHED_STATS_EN
    logic [15:0] stat_sent, stat_dropped, w_stat_sent, w_stat_dropped;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          send_cnt = 0;
    int          send_t[$];
    logic [24:0] exp_q[$];

    typedef struct {
        logic [5:0]  idx;
        logic [24:0] addr;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tx_send_scheduler #(.FIFO_DEPTH(8), .ADDR_SHIFT(19), .BASE_ADDR(25'h0), .GAP_CYCLES(GAP)) u_dut (
        .clock_clk(clk), .reset_reset_n(rst_n),
        .req_start_ram_addr(req_idx), .req_signal(req_sig),
        .mac_inited(mac), .clear_overflow(clr),
        .send_control_start_ram_addr(addr), .send_control_cmd_send(cmd),
        .fifo_level(level), .overflow_sticky(sticky)
`ifdef TX_SEND_SCHED_STATS_EN
        , .stat_sent(stat_sent), .stat_dropped(stat_dropped)
`endif
    );

    tx_send_scheduler #(.FIFO_DEPTH(8), .ADDR_SHIFT(19), .BASE_ADDR(25'h1F80000), .GAP_CYCLES(GAP)) u_wrap (
        .clock_clk(clk), .reset_reset_n(rst_n),
        .req_start_ram_addr(w_req_idx), .req_signal(w_req_sig),
        .mac_inited(w_mac), .clear_overflow(w_clr),
        .send_control_start_ram_addr(w_addr), .send_control_cmd_send(w_cmd),
        .fifo_level(w_level), .overflow_sticky(w_sticky)
`ifdef TX_SEND_SCHED_STATS_EN
        , .stat_sent(w_stat_sent), .stat_dropped(w_stat_dropped)
`endif
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [24:0] addr_of(input logic [5:0] idx);
        logic [24:0] v;
        v = {19'b0, idx};
        return v << 19;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [5:0] idx);
        req_idx = idx;
        req_sig = 1'b1;
        @(negedge clk);
        req_sig = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_drain(input string name, input int max);
        for (int i = 0; i < max && exp_q.size() != 0; i++) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'(0));
    endtask

    // Scoreboard: every strobe must match the oldest expected address, be one clock wide, and carry a settled address
    task automatic monitor();
        logic [24:0] prev_addr;
        logic        prev_cmd;
        logic [24:0] e;
        prev_addr = '0;
        prev_cmd  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_addr = '0;
                prev_cmd  = 1'b0;
            end else begin
                if (cmd) begin
                    send_cnt++;
                    send_t.push_back(cyc);
                    check("pulse_width", 32'(prev_cmd), 32'(0));
                    check("addr_stable", 32'(addr), 32'(prev_addr));
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_send actual addr=%0h required no send", addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("send_addr", 32'(addr), 32'(e));
                    end
                end
                prev_cmd  = cmd;
                prev_addr = addr;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit found;
        tbl[0] = '{6'd0,  25'h0000000};
        tbl[1] = '{6'd1,  25'h0080000};
        tbl[2] = '{6'd2,  25'h0100000};
        tbl[3] = '{6'd21, 25'h0A80000};
        tbl[4] = '{6'd32, 25'h1000000};
        tbl[5] = '{6'd63, 25'h1F80000};

        fork
            monitor();
        join_none

        // Reset state
        tick(2);
        check("rst_cmd", 32'(cmd), 32'(0));
        check("rst_addr", 32'(addr), 32'(0));
        check("rst_level", 32'(level), 32'(0));
        check("rst_sticky", 32'(sticky), 32'(0));
`ifdef TX_SEND_SCHED_STATS_EN
        check("rst_stat_sent", 32'(stat_sent), 32'(0));
        check("rst_stat_dropped", 32'(stat_dropped), 32'(0));
`endif
        rst_n = 1'b1;
        mac   = 1'b1;
        tick(2);

        // Single request latency
        req_idx = 6'd3;
        req_sig = 1'b1;
        exp_q.push_back(25'h180000);
        @(negedge clk);
        req_sig = 1'b0;
        check("t1_level_k", 32'(level), 32'(1));
        check("t1_cmd_k", 32'(cmd), 32'(0));
        check("t1_addr_k", 32'(addr), 32'(0));
        @(negedge clk);
        check("t1_addr_k1", 32'(addr), 32'(25'h180000));
        check("t1_cmd_k1", 32'(cmd), 32'(0));
        check("t1_level_k1", 32'(level), 32'(0));
        @(negedge clk);
        check("t1_cmd_k2", 32'(cmd), 32'(1));
        @(negedge clk);
        check("t1_cmd_k3", 32'(cmd), 32'(0));
        tick(GAP + 3);

        // Vector table
        for (int v = 0; v < 6; v++) begin
            exp_q.push_back(tbl[v].addr);
            pulse(tbl[v].idx);
            wait_drain("tbl_drain", 20);
            tick(GAP + 3);
            check("tbl_level", 32'(level), 32'(0));
        end

        // Burst of three: strobes GAP+3 apart
        send_t.delete();
        exp_q.push_back(25'h080000);
        pulse(6'd1);
        exp_q.push_back(25'h100000);
        pulse(6'd2);
        exp_q.push_back(25'h180000);
        pulse(6'd3);
        for (int i = 0; i < 60 && send_t.size() < 3; i++) @(negedge clk);
        check("t2_sends", 32'(send_t.size()), 32'(3));
        if (send_t.size() >= 3) begin
            check("t2_gap01", 32'(send_t[1] - send_t[0]), 32'(GAP + 3));
            check("t2_gap12", 32'(send_t[2] - send_t[1]), 32'(GAP + 3));
        end
        wait_drain("t2_drain", 10);
        tick(GAP + 3);

        // Overflow with MAC not ready
        mac  = 1'b0;
        base = send_cnt;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back(addr_of(6'(10 + i)));
            pulse(6'(10 + i));
        end
        check("t3_level_full", 32'(level), 32'(8));
        check("t3_sticky", 32'(sticky), 32'(1));
        check("t3_no_send", 32'(send_cnt), 32'(base));
`ifdef TX_SEND_SCHED_STATS_EN
        check("t3_stat_dropped", 32'(stat_dropped), 32'(1));
        check("t3_stat_sent", 32'(stat_sent), 32'(send_cnt));
`endif
        mac = 1'b1;
        wait_drain("t3_drain", 100);
        tick(15);
        check("t3_eight_sends", 32'(send_cnt), 32'(base + 8));
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t3_sticky_clr", 32'(sticky), 32'(0));
`ifdef TX_SEND_SCHED_STATS_EN
        check("t3_stat_clr", 32'({stat_sent, stat_dropped}), 32'(0));
`endif

        // Held level pushes once; clear loses to a coincident overflow
        mac     = 1'b0;
        req_idx = 6'd40;
        req_sig = 1'b1;
        exp_q.push_back(addr_of(6'd40));
        tick(20);
        req_sig = 1'b0;
        tick(1);
        check("t4_hold_level", 32'(level), 32'(1));
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(addr_of(6'(41 + i)));
            pulse(6'(41 + i));
        end
        check("t4_full", 32'(level), 32'(8));
        req_idx = 6'd50;
        req_sig = 1'b1;
        clr     = 1'b1;
        @(negedge clk);
        req_sig = 1'b0;
        clr     = 1'b0;
        check("t4_set_wins", 32'(sticky), 32'(1));
        check("t4_level_kept", 32'(level), 32'(8));
`ifdef TX_SEND_SCHED_STATS_EN
        check("t4_stat_clear_wins", 32'(stat_dropped), 32'(0));
`endif
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t4_sticky_clr", 32'(sticky), 32'(0));
        // Push into a full FIFO on the popping edge is accepted
        req_idx = 6'd51;
        req_sig = 1'b1;
        mac     = 1'b1;
        exp_q.push_back(addr_of(6'd51));
        @(negedge clk);
        req_sig = 1'b0;
        check("t4_pushpop_level", 32'(level), 32'(8));
        check("t4_pushpop_sticky", 32'(sticky), 32'(0));
        wait_drain("t4_drain", 120);
        tick(GAP + 3);
        check("t4_level_empty", 32'(level), 32'(0));

        // Asynchronous reset during the strobe
        base = send_cnt;
        exp_q.push_back(addr_of(6'd5));
        pulse(6'd5);
        req_idx = 6'd6;
        req_sig = 1'b1;
        found   = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            req_sig = 1'b0;
            found   = cmd;
        end
        check("t5_strobe_seen", 32'(found), 32'(1));
        check("t5_level_pre", 32'(level), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("t5_cmd_rst", 32'(cmd), 32'(0));
        check("t5_addr_rst", 32'(addr), 32'(0));
        check("t5_level_rst", 32'(level), 32'(0));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick(20);
        check("t5_no_send", 32'(send_cnt), 32'(base + 1));
        check("t5_level_after", 32'(level), 32'(0));

        // Address wrap on the offset-base instance
        w_mac     = 1'b1;
        w_req_idx = 6'd63;
        w_req_sig = 1'b1;
        @(negedge clk);
        w_req_sig = 1'b0;
        found     = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = w_cmd;
        end
        check("t6_strobe_seen", 32'(found), 32'(1));
        check("t6_wrap_addr", 32'(w_addr), 32'(25'h1F00000));
`ifdef TX_SEND_SCHED_STATS_EN
        check("t6_stat_sent", 32'(w_stat_sent), 32'(1));
`endif
        tick(GAP + 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
